// File: rtl/soc_fifo_pkg.sv
// rtl/soc_fifo_pkg.sv - shared types and helpers for the FIFO read-side stream engine
// Purpose: default word width, word/beat types and a saturating counter helper.
// Ports: none (package).
package soc_fifo_pkg;

   localparam int FIFO_DATA_W_DEF = 32;

   typedef logic [FIFO_DATA_W_DEF-1:0] fifo_word_t;

   // One observed stream beat; used by benches to describe expected output.
   typedef struct packed {
      logic       valid;
      fifo_word_t data;
   } stream_beat_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready stream interface of the FIFO reader
// Purpose: bundles the outgoing word stream.
// Ports (signals): valid - word present, data - word, ready - consumer accepts.
// Modports: master (reader side drives valid/data), slave (consumer drives ready).
interface fifo_stream_reader_if
   import soc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W_DEF
) ();

   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - small circular output buffer for the FIFO reader
// Purpose: BUF_DEPTH-entry ring with push/pop, occupancy count and head output.
// Ports: i_clk, i_rstn (async active-low), i_flush (sync clear of ptrs/count),
//        i_push/i_push_data (write at wr_ptr), i_pop (advance rd_ptr),
//        o_head (entry at rd_ptr), o_count (occupancy).
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_buf
   import soc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W_DEF,
   parameter int BUF_DEPTH  = 2,
   parameter int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [CNT_W-1:0]      o_count
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   // Pointers wrap naturally because BUF_DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (i_flush) begin
         // Contents are left in place; only the bookkeeping is cleared.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) begin
            mem[wr_ptr] <= i_push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (i_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_head  = mem[rd_ptr];
   assign o_count = count;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a Sync_FIFO read port into a valid/ready stream
// Purpose: issues FIFO reads only when buffer space is guaranteed, absorbs the
//          FIFO's one-cycle read latency and presents one word per cycle.
// Ports: i_clk, i_rstn (async active-low), i_flush (sync discard of buffered and
//        in-flight words), o_fifo_rd_en / i_fifo_rd_data / i_fifo_empty (FIFO read
//        port), strm (stream master: valid, data, ready), o_busy (buffer non-empty
//        or read in flight).
// Option: FIFO_RD_STATS_EN adds o_word_cnt and o_stall_cnt (saturating, cleared on
//         reset and flush).
module fifo_stream_reader
   import soc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W_DEF,
   parameter int BUF_DEPTH  = 2,
   parameter int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   output logic                  o_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
   input  logic                  i_fifo_empty,
   fifo_stream_reader_if.master  strm,
   output logic                  o_busy
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]           o_word_cnt,
   output logic [31:0]           o_stall_cnt
`endif
);

   logic                  pend;
   logic                  pop;
   logic [CNT_W-1:0]      count;
   logic [CNT_W:0]        committed;
   logic [DATA_WIDTH-1:0] head;

   assign pop = strm.valid && strm.ready;

   // Slots already spoken for after this cycle: held words plus the word in
   // flight, minus the one leaving now. A read is issued only if a slot remains,
   // so a captured word always has somewhere to land.
   assign committed    = {1'b0, count} + (CNT_W + 1)'(pend) - (CNT_W + 1)'(pop);
   assign o_fifo_rd_en = !i_fifo_empty && !i_flush &&
                         (committed < (CNT_W + 1)'(BUF_DEPTH));

   // Every strobe is an accepted read, so its data arrives next cycle.
   // rd_en is low during flush, which also clears pend.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pend <= 1'b0;
      end else begin
         pend <= o_fifo_rd_en;
      end
   end

   fifo_rd_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH),
      .CNT_W      (CNT_W)
   ) u_buf (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_flush     (i_flush),
      .i_push      (pend),
      .i_push_data (i_fifo_rd_data),
      .i_pop       (pop),
      .o_head      (head),
      .o_count     (count)
   );

   assign strm.valid = (count != '0);
   assign strm.data  = head;
   assign o_busy     = (count != '0) || pend;

`ifdef FIFO_RD_STATS_EN
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_word_cnt  <= '0;
         o_stall_cnt <= '0;
      end else if (i_flush) begin
         o_word_cnt  <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (pop) begin
            o_word_cnt <= sat_inc32(o_word_cnt);
         end
         if (strm.valid && !strm.ready) begin
            o_stall_cnt <= sat_inc32(o_stall_cnt);
         end
      end
   end
`endif

endmodule
